// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP pattern loader and its bus writer.
//   VDP_DATA_PORT / VDP_CTRL_PORT : I/O addresses of the VDP data and control ports
//   loader_state_e                : loader states; the writer reuses IDLE/SETUP/STROBE/HOLD
//   vdp_entry_t                   : one table word {is_ctrl, data_byte}
//   entry_port()                  : maps a table word to its destination port
//   phase_cnt_w()                 : width of the write-phase down-counter
package vdp_pkg;

  localparam logic [7:0] VDP_DATA_PORT = 8'hBE;
  localparam logic [7:0] VDP_CTRL_PORT = 8'hBF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    SETUP  = 3'd3,
    STROBE = 3'd4,
    HOLD   = 3'd5,
    DONE   = 3'd6
  } loader_state_e;

  typedef struct packed {
    logic       is_ctrl;
    logic [7:0] data_byte;
  } vdp_entry_t;

  function automatic logic [7:0] entry_port(input vdp_entry_t e);
    return e.is_ctrl ? VDP_CTRL_PORT : VDP_DATA_PORT;
  endfunction

  // ceil(log2(max+1)), never less than one bit
  function automatic int phase_cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/vdp_bus_writer.sv
// Performs one VDP I/O write: SETUP (data driven, strobes high), STROBE
// (IORQ_L/WR_L low), HOLD (data driven, strobes high). All outputs are flops,
// so the strobes cannot glitch; reset clears them asynchronously.
//   clk_100, rst_L    : clock, async active-low reset
//   i_req             : one-cycle request; i_addr/i_data are captured with it
//   o_ack             : pulses during the last HOLD cycle
//   o_data_oe         : data bus driven (SETUP/STROBE/HOLD)
//   o_iorq_l, o_wr_l  : active-low write strobes
//   o_addr, o_data    : port address and write byte, held after the cycle
module vdp_bus_writer
  import vdp_pkg::*;
#(
  parameter int SETUP_CYC  = 4,
  parameter int STROBE_CYC = 20,
  parameter int HOLD_CYC   = 4
) (
  input  logic       clk_100,
  input  logic       rst_L,
  input  logic       i_req,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_data,
  output logic       o_ack,
  output logic       o_data_oe,
  output logic       o_iorq_l,
  output logic       o_wr_l,
  output logic [7:0] o_addr,
  output logic [7:0] o_data
);

  localparam int CNT_W = phase_cnt_w(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  loader_state_e    r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack;
  logic             r_oe;
  logic             r_iorq_l;
  logic             r_wr_l;
  logic [7:0]       r_addr;
  logic [7:0]       r_data;

  // Phase sequencer: the counter holds the remaining cycles of the current phase
  always_ff @(posedge clk_100 or negedge rst_L) begin
    if (!rst_L) begin
      r_phase  <= IDLE;
      r_cnt    <= CNT_ZERO;
      r_ack    <= 1'b0;
      r_oe     <= 1'b0;
      r_iorq_l <= 1'b1;
      r_wr_l   <= 1'b1;
      r_addr   <= 8'h00;
      r_data   <= 8'h00;
    end else begin
      r_ack <= 1'b0;
      case (r_phase)
        IDLE: begin
          if (i_req) begin
            r_addr  <= i_addr;
            r_data  <= i_data;
            r_oe    <= 1'b1;
            r_phase <= SETUP;
            r_cnt   <= SETUP_LD;
          end
        end
        SETUP: begin
          if (r_cnt == CNT_ZERO) begin
            r_phase  <= STROBE;
            r_cnt    <= STROBE_LD;
            r_iorq_l <= 1'b0;
            r_wr_l   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        STROBE: begin
          if (r_cnt == CNT_ZERO) begin
            r_phase  <= HOLD;
            r_cnt    <= HOLD_LD;
            r_iorq_l <= 1'b1;
            r_wr_l   <= 1'b1;
            // a single-cycle HOLD is also the last one
            r_ack    <= (HOLD_CYC == 1);
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        HOLD: begin
          if (r_cnt == CNT_ZERO) begin
            r_phase <= IDLE;
            r_oe    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
            r_ack <= (r_cnt == CNT_ONE);
          end
        end
        default: begin
          r_phase  <= IDLE;
          r_oe     <= 1'b0;
          r_iorq_l <= 1'b1;
          r_wr_l   <= 1'b1;
        end
      endcase
    end
  end

  assign o_ack     = r_ack;
  assign o_data_oe = r_oe;
  assign o_iorq_l  = r_iorq_l;
  assign o_wr_l    = r_wr_l;
  assign o_addr    = r_addr;
  assign o_data    = r_data;

endmodule

// File: rtl/vdp_pattern_loader.sv
// Downloads tbl_len table entries to the VDP, one bus write per entry.
// Per entry: FETCH (tbl_rd), WAIT (table word arrives, handed to the writer),
// then the writer's SETUP/STROBE/HOLD cycle; 30 clocks with default timing.
//   clk_100, rst_L        : clock, async active-low reset
//   start, abort          : begin download / stop after the current write
//   tbl_len               : entry count, latched at start
//   tbl_addr, tbl_rd      : table read index and strobe
//   tbl_data              : {is_ctrl, byte}, valid the cycle after tbl_rd
//   addr_bus, data_bus    : VDP port and write byte (hold when idle)
//   data_oe               : data_bus driven
//   IORQ_L, WR_L, RD_L    : active-low bus strobes (RD_L always high)
//   busy, done            : download active / one-cycle completion pulse
module vdp_pattern_loader
  import vdp_pkg::*;
#(
  parameter int SETUP_CYC  = 4,
  parameter int STROBE_CYC = 20,
  parameter int HOLD_CYC   = 4
) (
  input  logic       clk_100,
  input  logic       rst_L,
  input  logic       start,
  input  logic       abort,
  input  logic [9:0] tbl_len,
  output logic [9:0] tbl_addr,
  output logic       tbl_rd,
  input  logic [8:0] tbl_data,
  output logic [7:0] addr_bus,
  output logic [7:0] data_bus,
  output logic       data_oe,
  output logic       IORQ_L,
  output logic       WR_L,
  output logic       RD_L,
  output logic       busy,
  output logic       done
);

  loader_state_e r_state;
  logic [9:0]    r_len;
  logic [9:0]    r_idx;
  logic          r_abort;
  logic          r_tbl_rd;
  logic [9:0]    r_tbl_addr;
  logic          r_req;
  logic          r_busy;
  logic          r_done;
  logic          r_rd_l;

  vdp_entry_t    w_entry;
  logic [9:0]    w_idx_nxt;
  logic          w_ack;

  assign w_entry   = tbl_data;
  // idx stops at tbl_len (max 1023), so this add never wraps in use
  assign w_idx_nxt = r_idx + 10'd1;

  vdp_bus_writer #(
    .SETUP_CYC  (SETUP_CYC),
    .STROBE_CYC (STROBE_CYC),
    .HOLD_CYC   (HOLD_CYC)
  ) u_writer (
    .clk_100   (clk_100),
    .rst_L     (rst_L),
    .i_req     (r_req),
    .i_addr    (entry_port(w_entry)),
    .i_data    (w_entry.data_byte),
    .o_ack     (w_ack),
    .o_data_oe (data_oe),
    .o_iorq_l  (IORQ_L),
    .o_wr_l    (WR_L),
    .o_addr    (addr_bus),
    .o_data    (data_bus)
  );

  // Download sequencer; outputs are registered for the state being entered
  always_ff @(posedge clk_100 or negedge rst_L) begin
    if (!rst_L) begin
      r_state    <= IDLE;
      r_len      <= 10'd0;
      r_idx      <= 10'd0;
      r_abort    <= 1'b0;
      r_tbl_rd   <= 1'b0;
      r_tbl_addr <= 10'd0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_l     <= 1'b1;
    end else begin
      r_rd_l <= 1'b1;
      case (r_state)
        IDLE: begin
          // abort is ignored here, so start wins when both are high
          if (start) begin
            r_len   <= tbl_len;
            r_idx   <= 10'd0;
            r_abort <= 1'b0;
            r_busy  <= 1'b1;
            if (tbl_len == 10'd0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= FETCH;
              r_tbl_rd   <= 1'b1;
              r_tbl_addr <= 10'd0;
            end
          end
        end
        FETCH: begin
          r_tbl_rd <= 1'b0;
          r_req    <= 1'b1;
          r_state  <= WAIT;
          if (abort) r_abort <= 1'b1;
        end
        WAIT: begin
          // the writer captures tbl_data on this edge
          r_req   <= 1'b0;
          r_state <= SETUP;
          if (abort) r_abort <= 1'b1;
        end
        SETUP, STROBE, HOLD: begin
          // the writer times the phases; wait here for its ack
          if (w_ack) begin
            r_idx <= w_idx_nxt;
            if ((w_idx_nxt == r_len) || r_abort || abort) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= FETCH;
              r_tbl_rd   <= 1'b1;
              r_tbl_addr <= w_idx_nxt;
              r_abort    <= 1'b0;
            end
          end else if (abort) begin
            r_abort <= 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_abort <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_tbl_rd <= 1'b0;
          r_req    <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign tbl_rd   = r_tbl_rd;
  assign tbl_addr = r_tbl_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign RD_L     = r_rd_l;

endmodule

// File: doc/vdp_pattern_loader.md
VDP_PATTERN_LOADER -- requirements
Module: vdp_pattern_loader

Interface
REQ-001 Parameters (name, default, meaning): SETUP_CYC, 4, clk_100 cycles from address/data valid to strobe fall; STROBE_CYC, 20, IORQ_L/WR_L low width; HOLD_CYC, 4, data/address hold after strobe rise.
REQ-002 Ports (name, direction, width, meaning): clk_100, in, 1, system clock; rst_L, in, 1, reset, asynchronous, active-low.
REQ-003 start, in, 1: begin download of tbl_len entries; abort, in, 1: stop after the current bus cycle.
REQ-004 tbl_len, in, 10: entry count, latched at start; tbl_addr, out, 10: table read index; tbl_rd, out, 1: table read strobe.
REQ-005 tbl_data, in, 9: bit8 = 1 for control port, 0 for data port; bits7:0 = byte; valid one cycle after tbl_rd.
REQ-006 addr_bus, out, 8: VDP I/O port; data_bus, out, 8: write byte; data_oe, out, 1: data_bus driven.
REQ-007 IORQ_L, WR_L, RD_L, out, 1 each: active-low bus strobes. RD_L is constant 1.
REQ-008 busy, out, 1: download in progress; done, out, 1: one-cycle completion pulse.

Function
REQ-009 States: IDLE, FETCH, WAIT, SETUP, STROBE, HOLD, DONE.
REQ-010 IDLE: start=1 latches tbl_len and clears idx to 0, then goes to FETCH. If tbl_len=0, the block goes to DONE instead.
REQ-011 FETCH (1 cycle): tbl_rd=1, tbl_addr=idx, then WAIT.
REQ-012 WAIT (1 cycle): registers tbl_data and sets addr_bus to 8'hBF if bit8=1, else 8'hBE. data_bus gets bits7:0. Next state is SETUP.
REQ-013 SETUP (SETUP_CYC cycles): data_oe=1 with strobes high. STROBE (STROBE_CYC cycles): data_oe=1, IORQ_L=0, WR_L=0. HOLD (HOLD_CYC cycles): data_oe=1 with strobes high.
REQ-014 Strobes are driven from registered outputs only and are glitch-free.
REQ-015 HOLD exit: idx increments. If idx+1 = tbl_len, or abort was seen during this entry, the block goes to DONE; otherwise to FETCH.
REQ-016 DONE (1 cycle): done=1, then IDLE.
REQ-017 busy=1 in every state except IDLE.
REQ-018 Per-entry cost is 2+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles, i.e. 30 with defaults.
REQ-019 start is sampled in cycle T. tbl_rd is high in T+1. IORQ_L is low T+7..T+26 and high again at T+27. The next tbl_rd is at T+31.
REQ-020 start while busy is ignored. start and abort together in IDLE: start wins.
REQ-021 abort is sticky within an entry. It never shortens an active strobe. It is ignored in IDLE and DONE.
REQ-022 Phase counter width is ceil(log2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1)). idx is 10 bits. tbl_len=1023 is supported, and idx never wraps.
REQ-023 data_oe=0 outside SETUP, STROBE and HOLD. data_bus and addr_bus hold their last value when not driven.

Reset
REQ-024 rst_L low immediately forces state=IDLE, IORQ_L=1, WR_L=1, RD_L=1, data_oe=0, busy=0, done=0, tbl_rd=0, tbl_addr=0, addr_bus=0, data_bus=0, idx=0, abort flag=0.
REQ-025 Reset mid-strobe ends the strobe asynchronously. After reset release, no partial cycle resumes; a new start is required.

Structure
REQ-026 Shared package vdp_pkg holds VDP_DATA_PORT=8'hBE, VDP_CTRL_PORT=8'hBF, the loader state enum, and the packed table-entry typedef {is_ctrl, byte}.
REQ-027 One sub-module, vdp_bus_writer, performs a single SETUP/STROBE/HOLD write cycle with a req/ack handshake. ack pulses in the last HOLD cycle. The loader FSM sequences fetches around it.

Verification
REQ-028 tbl_len=1, entry 9'h1_81, start at T: tbl_rd at T+1; addr_bus=BF and data_bus=81 at T+3; IORQ_L/WR_L low T+7..T+26; done at T+31; busy low at T+32.
REQ-029 tbl_len=3, entries {0_AA, 1_40, 0_55}: exactly three strobes of 20 cycles each, 30 cycles apart, to ports BE, BF, BE with data AA, 40, 55; a single done pulse.
REQ-030 tbl_len=0 with start: no tbl_rd and no strobe; done one cycle after start.
REQ-031 tbl_len=5, abort pulsed during the strobe of entry 2: that strobe completes its full 20 cycles, no further tbl_rd occurs, then done follows.
REQ-032 rst_L dropped on cycle 10 of a strobe: IORQ_L, WR_L and data_oe return high/high/0 without a clock edge; after release the outputs stay idle until a new start.
REQ-033 start re-pulsed while busy: sequence and timing identical to REQ-029; done pulses once.
